// File: rtl/range_merge_stream.sv
// range_merge_stream
//   Streaming merger of inclusive ID ranges that arrive sorted by start.
//   Overlapping ranges are merged; when ADJ_MERGE is set, touching ranges
//   (next start == current end + 1) are merged too. Each merged range is
//   emitted through a one-entry output slot. Alongside the emitted ranges
//   the block keeps the total covered-ID count and the number of merged
//   ranges. After the range tagged last has been emitted, done is raised.
//
// Ports
//   clk, reset          rising-edge clock, async active-high reset
//   restart             sync pulse; leaves DONE (only when slot is empty)
//   in_valid/in_ready   input handshake; in_start/in_end/in_last payload
//   out_valid/out_ready output handshake; out_start/out_end merged range
//   total_count         sum of merged range lengths (wraps mod 2^CW)
//   range_cnt           merged ranges emitted (wraps mod 2^NW)
//   done                final results valid
//   err_order           sticky: a range with start > end was dropped
//   err_unsorted        sticky: a range started below the current start
module range_merge_stream #(
    parameter int W         = 50,
    parameter int CW        = 64,
    parameter int NW        = 16,
    parameter int ADJ_MERGE = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_start,
    input  logic [W-1:0]  in_end,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_start,
    output logic [W-1:0]  out_end,
    output logic [CW-1:0] total_count,
    output logic [NW-1:0] range_cnt,
    output logic          done,
    output logic          err_order,
    output logic          err_unsorted
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH, S_DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   cur_start, cur_end;

    logic           slot_free, accept, in_bad, merge_hit, rdy;
    logic           cur_ld, cur_ext, emit, set_eo, set_eu, clr;
    logic [W:0]     cur_len;

    assign slot_free = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign in_bad    = in_start > in_end;
    // Evaluated one bit wider so cur_end = 2^W-1 plus the adjacency step
    // cannot wrap to zero and refuse a legitimate merge.
    assign merge_hit = {1'b0, in_start} <= ({1'b0, cur_end} + (W+1)'(ADJ_MERGE));
    // cur_start <= cur_end always holds: loaded only from valid ranges and
    // cur_end only ever grows.
    assign cur_len   = {1'b0, cur_end} - {1'b0, cur_start} + (W+1)'(1);

    // in_ready is forced low while reset is asserted so every output reads
    // zero during reset, not only after it.
    assign in_ready  = rdy && !reset;
    assign done      = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        cur_ld    = 1'b0;
        cur_ext   = 1'b0;
        emit      = 1'b0;
        set_eo    = 1'b0;
        set_eu    = 1'b0;
        clr       = 1'b0;
        case (state)
            S_IDLE: begin
                rdy = 1'b1;
                if (accept) begin
                    if (in_bad) begin
                        set_eo = 1'b1;
                        if (in_last) state_nxt = S_DONE;
                    end else begin
                        cur_ld    = 1'b1;
                        state_nxt = in_last ? S_FLUSH : S_ACTIVE;
                    end
                end
            end
            S_ACTIVE: begin
                rdy = slot_free;
                if (accept) begin
                    if (in_bad) begin
                        set_eo = 1'b1;
                    end else begin
                        // cur_start is never lowered: an unsorted range is
                        // flagged and then merged against cur_end only.
                        if (in_start < cur_start) set_eu = 1'b1;
                        if (merge_hit) begin
                            cur_ext = 1'b1;
                        end else begin
                            emit   = 1'b1;
                            cur_ld = 1'b1;
                        end
                    end
                    if (in_last) state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (slot_free) begin
                    emit      = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (restart && !out_valid) begin
                    clr       = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cur_start    <= '0;
            cur_end      <= '0;
            out_valid    <= 1'b0;
            out_start    <= '0;
            out_end      <= '0;
            total_count  <= '0;
            range_cnt    <= '0;
            err_order    <= 1'b0;
            err_unsorted <= 1'b0;
        end else begin
            state <= state_nxt;

            if (cur_ld) begin
                cur_start <= in_start;
                cur_end   <= in_end;
            end else if (cur_ext && (in_end > cur_end)) begin
                cur_end <= in_end;
            end

            // Accounting is done as the range enters the slot, so the final
            // totals are already in place when done rises.
            if (emit) begin
                out_valid   <= 1'b1;
                out_start   <= cur_start;
                out_end     <= cur_end;
                total_count <= total_count + CW'(cur_len);
                range_cnt   <= range_cnt + NW'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (clr) begin
                total_count  <= '0;
                range_cnt    <= '0;
                err_order    <= 1'b0;
                err_unsorted <= 1'b0;
            end else begin
                if (set_eo) err_order    <= 1'b1;
                if (set_eu) err_unsorted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_range_merge_stream.sv
module tb_range_merge_stream;

    localparam int W  = 50;
    localparam int CW = 64;
    localparam int NW = 16;
    localparam longint MAXV = (64'd1 << W) - 1;

    logic clk, reset;
    logic          restart      [2];
    logic          in_valid     [2];
    logic          in_ready     [2];
    logic [W-1:0]  in_start     [2];
    logic [W-1:0]  in_end       [2];
    logic          in_last      [2];
    logic          out_valid    [2];
    logic          out_ready    [2];
    logic [W-1:0]  out_start    [2];
    logic [W-1:0]  out_end      [2];
    logic [CW-1:0] total_count  [2];
    logic [NW-1:0] range_cnt    [2];
    logic          done         [2];
    logic          err_order    [2];
    logic          err_unsorted [2];

    // instance 0 merges adjacent ranges, instance 1 only true overlaps
    range_merge_stream #(.W(W), .CW(CW), .NW(NW), .ADJ_MERGE(1)) u_dut_adj (
        .clk(clk), .reset(reset), .restart(restart[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_start(in_start[0]), .in_end(in_end[0]), .in_last(in_last[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_start(out_start[0]), .out_end(out_end[0]),
        .total_count(total_count[0]), .range_cnt(range_cnt[0]), .done(done[0]),
        .err_order(err_order[0]), .err_unsorted(err_unsorted[0]));

    range_merge_stream #(.W(W), .CW(CW), .NW(NW), .ADJ_MERGE(0)) u_dut_ovl (
        .clk(clk), .reset(reset), .restart(restart[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_start(in_start[1]), .in_end(in_end[1]), .in_last(in_last[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_start(out_start[1]), .out_end(out_end[1]),
        .total_count(total_count[1]), .range_cnt(range_cnt[1]), .done(done[1]),
        .err_order(err_order[1]), .err_unsorted(err_unsorted[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // stimulus set and reference results
    longint     set_s[$], set_e[$];
    longint     exp_s[$], exp_e[$];
    logic [63:0] exp_tot;
    logic        exp_eo, exp_eu;

    task automatic set_add(input longint s, input longint e);
        set_s.push_back(s);
        set_e.push_back(e);
    endtask

    task automatic set_clear();
        set_s.delete();
        set_e.delete();
    endtask

    // Sweep the set in arrival order: invalid ranges only flag, the open
    // range grows while the next start falls inside (or touches, with adj)
    // it, otherwise it is closed and a new one opens.
    function automatic void build_model(input int adj);
        longint cs, ce, s, e;
        bit have;
        exp_s.delete();
        exp_e.delete();
        exp_tot = '0;
        exp_eo  = 1'b0;
        exp_eu  = 1'b0;
        have = 0;
        cs = 0;
        ce = 0;
        for (int i = 0; i < set_s.size(); i++) begin
            s = set_s[i];
            e = set_e[i];
            if (s > e) begin
                exp_eo = 1'b1;
            end else if (!have) begin
                cs = s; ce = e; have = 1;
            end else begin
                if (s < cs) exp_eu = 1'b1;
                if (s <= ce + adj) begin
                    if (e > ce) ce = e;
                end else begin
                    exp_s.push_back(cs);
                    exp_e.push_back(ce);
                    cs = s; ce = e;
                end
            end
        end
        if (have) begin
            exp_s.push_back(cs);
            exp_e.push_back(ce);
        end
        for (int i = 0; i < exp_s.size(); i++)
            exp_tot = exp_tot + 64'(exp_e[i] - exp_s[i] + 1);
    endfunction

    // Drive the current set into DUT d, collect outputs, compare against the
    // model, then restart the DUT and confirm it cleared.
    task automatic run_set(input int d, input int vpct, input int rpct, input int stall_n);
        longint got_s[$], got_e[$];
        int idx, n, cyc, stall, hold_err, rdy_err, done_err;
        bit first_ov, done_seen, finished, prev_ov, prev_rdy;
        logic [W-1:0] prev_s, prev_e;
        build_model(d == 0 ? 1 : 0);
        n = set_s.size();
        idx = 0; cyc = 0; stall = 0; hold_err = 0; rdy_err = 0; done_err = 0;
        first_ov = 0; done_seen = 0; finished = 0; prev_ov = 0; prev_rdy = 1;
        prev_s = '0; prev_e = '0;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (prev_ov && !prev_rdy &&
                (!out_valid[d] || out_start[d] !== prev_s || out_end[d] !== prev_e))
                hold_err++;
            if (out_valid[d] && !first_ov && stall_n > 0) begin
                first_ov = 1;
                stall = stall_n;
            end
            if (stall > 0) begin
                out_ready[d] = 1'b0;
                stall--;
            end else begin
                out_ready[d] = ($urandom_range(99) < rpct);
            end
            if (idx < n) begin
                in_valid[d] = ($urandom_range(99) < vpct);
                in_start[d] = W'(set_s[idx]);
                in_end[d]   = W'(set_e[idx]);
                in_last[d]  = (idx == n - 1);
            end else begin
                in_valid[d] = 1'b0;
            end
            #1;
            if (done[d] && !done_seen) begin
                done_seen = 1;
                if (out_valid[d] !== (exp_s.size() > 0)) done_err++;
            end
            if (done[d] && in_ready[d]) rdy_err++;
            if (out_valid[d] && !out_ready[d] && in_ready[d]) rdy_err++;
            if (in_valid[d] && in_ready[d]) idx++;
            if (out_valid[d] && out_ready[d]) begin
                got_s.push_back(longint'(out_start[d]));
                got_e.push_back(longint'(out_end[d]));
            end
            prev_ov = out_valid[d]; prev_rdy = out_ready[d];
            prev_s = out_start[d]; prev_e = out_end[d];
            if (done_seen && !out_valid[d] && idx == n) begin
                finished = 1;
                break;
            end
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
        check("finish", 64'(finished), 64'd1);
        check("n_out", 64'(got_s.size()), 64'(exp_s.size()));
        for (int i = 0; i < exp_s.size() && i < got_s.size(); i++) begin
            check("out_start", 64'(got_s[i]), 64'(exp_s[i]));
            check("out_end", 64'(got_e[i]), 64'(exp_e[i]));
        end
        check("total_count", total_count[d], exp_tot);
        check("range_cnt", 64'(range_cnt[d]), 64'(NW'(exp_s.size())));
        check("err_order", 64'(err_order[d]), 64'(exp_eo));
        check("err_unsorted", 64'(err_unsorted[d]), 64'(exp_eu));
        check("done", 64'(done[d]), 64'(finished));
        check("hold_stable", 64'(hold_err), 64'd0);
        check("in_ready_block", 64'(rdy_err), 64'd0);
        check("done_with_last", 64'(done_err), 64'd0);
        @(negedge clk);
        restart[d] = 1'b1;
        @(negedge clk);
        restart[d] = 1'b0;
        #1;
        check("restart_done", 64'(done[d]), 64'd0);
        check("restart_total", total_count[d], 64'd0);
        check("restart_cnt", 64'(range_cnt[d]), 64'd0);
        check("restart_err", 64'({err_order[d], err_unsorted[d]}), 64'd0);
        check("restart_rdy", 64'(in_ready[d]), 64'd1);
    endtask

    task automatic set_aoc();
        set_clear();
        set_add(3, 5); set_add(10, 14); set_add(12, 18); set_add(16, 20);
    endtask

    initial begin
        int sent, n;
        longint base, s, e;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            restart[d] = 0; in_valid[d] = 0; in_start[d] = '0; in_end[d] = '0;
            in_last[d] = 0; out_ready[d] = 0;
        end
        #1;
        check("rst_outputs", 64'({in_ready[0], out_valid[0], done[0], err_order[0],
                                  err_unsorted[0]}), 64'd0);
        check("rst_out_range", 64'({out_start[0], out_end[0]} != '0), 64'd0);
        check("rst_counts", total_count[0] | 64'(range_cnt[0]), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // sample set, free-flowing output
        set_aoc();
        run_set(0, 100, 100, 0);
        // restart discards the previous totals
        set_clear(); set_add(100, 100);
        run_set(0, 100, 100, 0);
        // adjacency with and without merging
        set_clear(); set_add(1, 2); set_add(3, 4);
        run_set(0, 100, 100, 0);
        run_set(1, 100, 100, 0);
        // backpressure on the first output
        set_aoc();
        run_set(0, 100, 100, 5);
        // order and sort errors
        set_clear(); set_add(5, 3); set_add(7, 9); set_add(2, 8);
        run_set(0, 100, 100, 0);
        // a lone dropped range still finishes with nothing emitted
        set_clear(); set_add(9, 4);
        run_set(1, 100, 100, 0);
        // full-width range and a merge at the top of the value space
        set_clear(); set_add(0, MAXV);
        run_set(0, 100, 100, 0);
        set_clear(); set_add(0, MAXV); set_add(MAXV, MAXV);
        run_set(0, 100, 100, 0);
        set_clear(); set_add(MAXV - 3, MAXV - 1); set_add(MAXV, MAXV);
        run_set(0, 100, 100, 0);
        run_set(1, 100, 100, 0);

        // reset in the middle of a stream
        sent = 0;
        out_ready[0] = 1'b0;
        for (int c = 0; c < 20 && sent < 2; c++) begin
            @(negedge clk);
            in_valid[0] = 1'b1;
            in_start[0] = (sent == 0) ? W'(3) : W'(10);
            in_end[0]   = (sent == 0) ? W'(5) : W'(14);
            in_last[0]  = 1'b0;
            #1;
            if (in_ready[0]) sent++;
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        check("pre_rst_total", total_count[0], 64'd3);
        reset = 1'b1;
        #1;
        check("midrst_outputs", 64'({in_ready[0], out_valid[0], done[0], err_order[0],
                                     err_unsorted[0]}), 64'd0);
        check("midrst_range", 64'({out_start[0], out_end[0]} != '0), 64'd0);
        check("midrst_counts", total_count[0] | 64'(range_cnt[0]), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        set_aoc();
        run_set(0, 100, 100, 0);

        // randomized sets on both variants
        for (int t = 0; t < 40; t++) begin
            set_clear();
            n = $urandom_range(1, 8);
            base = $urandom_range(0, 20);
            for (int i = 0; i < n; i++) begin
                base = base + $urandom_range(0, 6);
                s = base;
                e = base + $urandom_range(0, 8);
                if ($urandom_range(9) == 0) e = s - 1 - $urandom_range(0, 2);
                else if ($urandom_range(9) == 0 && s >= 5) s = s - $urandom_range(1, 5);
                if (e < 0) e = 0;
                set_add(s, e);
            end
            run_set(t % 2, $urandom_range(50, 100), $urandom_range(30, 100), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
